// File: rtl/uart_tx_module.sv
// UART transmitter: one parallel word per accepted request becomes a start bit,
// LSB-first data, optional parity and one or two stop bits on a registered TXD.
module uart_tx_module #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLOCK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] TX_Data,
  input  logic                 TX_En_Sig,
  output logic                 TX_Ready,
  output logic                 TX_Done_Sig,
  output logic                 TXD
);

  localparam int BPS = CLK_FREQ / BAUD;
  localparam int CW  = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(BPS - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 bitEnd;

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
    end
  end

  assign bitEnd = (cnt_q == CNT_MAX);

  // txd_d is the value the line takes in the next cycle, so TXD leaves a flop only
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    txd_d    = txd_q;
    done_d   = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = '0;
      idx_d = '0;
      txd_d = 1'b1;
      if (TX_En_Sig) begin
        shift_d  = TX_Data;
        parity_d = (PARITY == 1) ? ~(^TX_Data) : (^TX_Data);
        txd_d    = 1'b0;
        state_d  = START;
      end
    end else if (!bitEnd) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
      case (state_q)
        START: begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (PARITY != 0) begin
              txd_d   = parity_q;
              state_d = PAR;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        PAR: begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          txd_d = 1'b1;
          if (idx_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign TX_Ready    = (state_q == IDLE);
  assign TX_Done_Sig = done_q;
  assign TXD         = txd_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module at BPS=10: four framings (8N1, 8E1, 8O1, 8E2)
// are checked cycle by cycle against a waveform built from the bench's own frame model.
module tb_uart_tx_module;

  logic       clock;
  logic       rst;
  logic [7:0] txData;
  logic       en    [4];
  logic       ready [4];
  logic       done  [4];
  logic       txd   [4];

  int total = 0;
  int bad   = 0;

  // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8E2
  uart_tx_module #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutN (
    .CLOCK(clock), .RST(rst), .TX_Data(txData), .TX_En_Sig(en[0]),
    .TX_Ready(ready[0]), .TX_Done_Sig(done[0]), .TXD(txd[0]));
  uart_tx_module #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutE (
    .CLOCK(clock), .RST(rst), .TX_Data(txData), .TX_En_Sig(en[1]),
    .TX_Ready(ready[1]), .TX_Done_Sig(done[1]), .TXD(txd[1]));
  uart_tx_module #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutO (
    .CLOCK(clock), .RST(rst), .TX_Data(txData), .TX_En_Sig(en[2]),
    .TX_Ready(ready[2]), .TX_Done_Sig(done[2]), .TXD(txd[2]));
  uart_tx_module #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dutE2 (
    .CLOCK(clock), .RST(rst), .TX_Data(txData), .TX_En_Sig(en[3]),
    .TX_Ready(ready[3]), .TX_Done_Sig(done[3]), .TXD(txd[3]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int parityMode(input int sel);
    return (sel == 0) ? 0 : (sel == 2) ? 1 : 2;
  endfunction

  function automatic int stopBits(input int sel);
    return (sel == 3) ? 2 : 1;
  endfunction

  function automatic int frameLen(input int sel);
    return (1 + 8 + ((parityMode(sel) != 0) ? 1 : 0) + stopBits(sel)) * 10;
  endfunction

  // Expected line level in cycle c (cycle 1 = first cycle after the accept edge)
  function automatic logic expBit(input int sel, input logic [7:0] d, input int c);
    int idx;
    int ones;
    idx  = (c - 1) / 10;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && parityMode(sel) == 2) return logic'(ones % 2 == 1);
    if (idx == 9 && parityMode(sel) == 1) return logic'(ones % 2 == 0);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // Sends one word on instance sel and checks TXD/TX_Ready/TX_Done_Sig every cycle
  // through the done cycle. holdEn keeps the request high for a back-to-back frame;
  // injectCycle (>0) pulses a 0xFF request during that busy cycle.
  task automatic applyStimulus(input int sel, input logic [7:0] d, input bit holdEn,
                               input int injectCycle, input string tag);
    int f;
    f = frameLen(sel);
    @(negedge clock);
    txData  = d;
    en[sel] = 1'b1;
    @(posedge clock);
    #1;
    if (!holdEn) en[sel] = 1'b0;
    txData = ~d;
    for (int c = 1; c <= f + 1; c++) begin
      if (injectCycle > 0 && c == injectCycle + 1) en[sel] = 1'b0;
      checkOutput({tag, " txd"},   c, 32'(txd[sel]),   32'(expBit(sel, d, c)));
      checkOutput({tag, " ready"}, c, 32'(ready[sel]), 32'(c == f + 1));
      checkOutput({tag, " done"},  c, 32'(done[sel]),  32'(c == f + 1));
      if (c == injectCycle) begin
        en[sel] = 1'b1;
        txData  = 8'hFF;
      end
      if (c <= f) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    txData = 8'h00;
    for (int i = 0; i < 4; i++) en[i] = 1'b0;

    #2;
    for (int i = 0; i < 4; i++) begin
      checkOutput("reset txd",   i, 32'(txd[i]),   32'd1);
      checkOutput("reset ready", i, 32'(ready[i]), 32'd1);
      checkOutput("reset done",  i, 32'(done[i]),  32'd0);
    end
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;

    $display("[TB] T1 8N1 0x55");
    applyStimulus(0, 8'h55, 1'b0, 0, "t1_8n1_55");

    $display("[TB] T2 parity frames");
    applyStimulus(1, 8'h55, 1'b0, 0, "t2_even_55");
    applyStimulus(2, 8'h55, 1'b0, 0, "t2_odd_55");
    applyStimulus(1, 8'h01, 1'b0, 0, "t2_even_01");
    applyStimulus(2, 8'h00, 1'b0, 0, "t2_odd_00");
    applyStimulus(3, 8'hC3, 1'b0, 0, "t2_8e2_c3");
    applyStimulus(3, 8'h07, 1'b0, 0, "t2_8e2_07");

    $display("[TB] T3 back-to-back 0xA3 then 0x3C");
    applyStimulus(0, 8'hA3, 1'b1, 0, "t3_first");
    applyStimulus(0, 8'h3C, 1'b0, 0, "t3_second");

    $display("[TB] T4 request while busy");
    applyStimulus(0, 8'h00, 1'b0, 40, "t4_busy");
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      checkOutput("t4 idle txd",   c, 32'(txd[0]),   32'd1);
      checkOutput("t4 idle ready", c, 32'(ready[0]), 32'd1);
      checkOutput("t4 idle done",  c, 32'(done[0]),  32'd0);
    end

    $display("[TB] T5 reset mid-frame");
    @(negedge clock);
    txData = 8'h00;
    en[0]  = 1'b1;
    @(posedge clock);
    #1;
    en[0] = 1'b0;
    repeat (34) @(posedge clock);
    #1;
    checkOutput("t5 pre-reset txd", 35, 32'(txd[0]), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("t5 reset txd",   35, 32'(txd[0]),   32'd1);
    checkOutput("t5 reset ready", 35, 32'(ready[0]), 32'd1);
    checkOutput("t5 reset done",  35, 32'(done[0]),  32'd0);
    for (int c = 36; c < 39; c++) begin
      @(posedge clock);
      #1;
      checkOutput("t5 held txd",  c, 32'(txd[0]),  32'd1);
      checkOutput("t5 held done", c, 32'(done[0]), 32'd0);
    end
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("t5 after txd",  0, 32'(txd[0]),  32'd1);
    checkOutput("t5 after done", 0, 32'(done[0]), 32'd0);
    applyStimulus(0, 8'hA5, 1'b0, 0, "t5_clean");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
